// File: rtl/zap_mem_inv_nway.sv
// Multi-way valid-bit RAM. Each way has a byte-writable data array and a per-entry valid bit.
// The read pipeline forwards in-flight writes and invalidates, so a read never returns stale data.
module zap_mem_inv_nway #(
    parameter int DEPTH  = 32,
    parameter int WIDTH  = 32,
    parameter int WAYS   = 2,
    parameter int RD_LAT = 2
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      i_clken,
    input  logic                      i_wen,
    input  logic [WAYS-1:0]           i_wway,
    input  logic [$clog2(DEPTH)-1:0]  i_waddr,
    input  logic [WIDTH-1:0]          i_wdata,
    input  logic [WIDTH/8-1:0]        i_wben,
    input  logic [$clog2(DEPTH)-1:0]  i_raddr,
    input  logic                      i_inv,
    input  logic                      i_inv_line,
    input  logic [$clog2(DEPTH)-1:0]  i_inv_addr,
    output logic [WAYS*WIDTH-1:0]     o_rdata,
    output logic [WAYS-1:0]           o_rdav
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = WIDTH / 8;

    logic [WIDTH-1:0]      mem_q [WAYS][DEPTH];
    logic [DEPTH-1:0]      vld_q [WAYS];
    logic [DEPTH-1:0]      vld_d [WAYS];
    logic [WAYS-1:0]       wr_way;

    logic [AW-1:0]         s1_addr_q, s1_addr_d;
    logic [WAYS*WIDTH-1:0] s1_data_q, s1_data_d;
    logic [WAYS-1:0]       s1_vld_q,  s1_vld_d;

    function automatic logic [WIDTH-1:0] merge_bytes(input logic [WIDTH-1:0] old_v,
                                                     input logic [WIDTH-1:0] new_v,
                                                     input logic [BW-1:0]    ben);
        logic [WIDTH-1:0] r;
        r = old_v;
        for (int b = 0; b < BW; b++) begin
            if (ben[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

    assign wr_way = {WAYS{i_wen & i_clken}} & i_wway;

    // Array contents are deliberately left out of reset.
    always_ff @(posedge i_clk) begin
        for (int w = 0; w < WAYS; w++) begin
            if (wr_way[w]) mem_q[w][i_waddr] <= merge_bytes(mem_q[w][i_waddr], i_wdata, i_wben);
        end
    end

    // Invalidate beats line invalidate beats write on the valid bits.
    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            vld_d[w] = vld_q[w];
            if (wr_way[w]) vld_d[w][i_waddr] = 1'b1;
            if (i_inv_line) vld_d[w][i_inv_addr] = 1'b0;
            if (i_inv) vld_d[w] = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int w = 0; w < WAYS; w++) vld_q[w] <= '0;
        end else begin
            for (int w = 0; w < WAYS; w++) vld_q[w] <= vld_d[w];
        end
    end

    always_comb begin
        s1_addr_d = i_clken ? i_raddr : s1_addr_q;
        s1_data_d = s1_data_q;
        s1_vld_d  = s1_vld_q;
        for (int w = 0; w < WAYS; w++) begin
            if (i_clken) begin
                s1_data_d[w*WIDTH +: WIDTH] = mem_q[w][i_raddr];
                s1_vld_d[w]                 = vld_q[w][i_raddr];
                if (wr_way[w] && i_waddr == i_raddr) begin
                    s1_data_d[w*WIDTH +: WIDTH] = merge_bytes(mem_q[w][i_raddr], i_wdata, i_wben);
                    s1_vld_d[w]                 = 1'b1;
                end
            end
            if (i_inv_line && s1_addr_d == i_inv_addr) s1_vld_d[w] = 1'b0;
            if (i_inv) s1_vld_d[w] = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s1_addr_q <= '0;
            s1_data_q <= '0;
            s1_vld_q  <= '0;
        end else begin
            s1_addr_q <= s1_addr_d;
            s1_data_q <= s1_data_d;
            s1_vld_q  <= s1_vld_d;
        end
    end

    if (RD_LAT == 1) begin : g_lat1
        assign o_rdata = s1_data_q;
        assign o_rdav  = s1_vld_q;
    end else if (RD_LAT == 2) begin : g_lat2
        logic [AW-1:0]         s2_addr_q, s2_addr_d;
        logic [WAYS*WIDTH-1:0] s2_data_q, s2_data_d;
        logic [WAYS-1:0]       s2_vld_q,  s2_vld_d;

        // The entry moving out of stage 1 still picks up a write to its index.
        always_comb begin
            s2_addr_d = i_clken ? s1_addr_q : s2_addr_q;
            s2_data_d = s2_data_q;
            s2_vld_d  = s2_vld_q;
            for (int w = 0; w < WAYS; w++) begin
                if (i_clken) begin
                    s2_data_d[w*WIDTH +: WIDTH] = s1_data_q[w*WIDTH +: WIDTH];
                    s2_vld_d[w]                 = s1_vld_q[w];
                    if (wr_way[w] && i_waddr == s1_addr_q) begin
                        s2_data_d[w*WIDTH +: WIDTH] =
                            merge_bytes(s1_data_q[w*WIDTH +: WIDTH], i_wdata, i_wben);
                        s2_vld_d[w] = 1'b1;
                    end
                end
                if (i_inv_line && s2_addr_d == i_inv_addr) s2_vld_d[w] = 1'b0;
                if (i_inv) s2_vld_d[w] = 1'b0;
            end
        end

        always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
                s2_addr_q <= '0;
                s2_data_q <= '0;
                s2_vld_q  <= '0;
            end else begin
                s2_addr_q <= s2_addr_d;
                s2_data_q <= s2_data_d;
                s2_vld_q  <= s2_vld_d;
            end
        end

        assign o_rdata = s2_data_q;
        assign o_rdav  = s2_vld_q;
    end else begin : g_bad_lat
        $error("zap_mem_inv_nway: RD_LAT must be 1 or 2");
    end

endmodule

// File: tb/tb_zap_mem_inv_nway.sv
// Bench for zap_mem_inv_nway: RD_LAT=2 and RD_LAT=1 instances share stimulus and are
// checked against an array-level model of contents, valid bits and read addresses.
module tb_zap_mem_inv_nway;

    localparam int DEPTH = 32;
    localparam int WIDTH = 32;
    localparam int WAYS  = 2;
    localparam int AW    = 5;
    localparam int BW    = 4;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  clken, wen, inv, inv_line;
    logic [WAYS-1:0]       wway;
    logic [AW-1:0]         waddr, raddr, inv_addr;
    logic [WIDTH-1:0]      wdata;
    logic [BW-1:0]         wben;
    logic [WAYS*WIDTH-1:0] rdata1, rdata2;
    logic [WAYS-1:0]       rdav1, rdav2;

    int tests = 0;
    int fails = 0;

    logic [WIDTH-1:0] m_data  [WAYS][DEPTH];
    logic [BW-1:0]    m_known [WAYS][DEPTH];
    bit               m_vld   [WAYS][DEPTH];
    logic [AW-1:0]    p1, p2;

    always #5 clk = ~clk;

    zap_mem_inv_nway #(.DEPTH(DEPTH), .WIDTH(WIDTH), .WAYS(WAYS), .RD_LAT(2)) u_dut2 (
        .i_clk(clk), .i_reset_n(reset_n), .i_clken(clken), .i_wen(wen), .i_wway(wway),
        .i_waddr(waddr), .i_wdata(wdata), .i_wben(wben), .i_raddr(raddr), .i_inv(inv),
        .i_inv_line(inv_line), .i_inv_addr(inv_addr), .o_rdata(rdata2), .o_rdav(rdav2));

    zap_mem_inv_nway #(.DEPTH(DEPTH), .WIDTH(WIDTH), .WAYS(WAYS), .RD_LAT(1)) u_dut1 (
        .i_clk(clk), .i_reset_n(reset_n), .i_clken(clken), .i_wen(wen), .i_wway(wway),
        .i_waddr(waddr), .i_wdata(wdata), .i_wben(wben), .i_raddr(raddr), .i_inv(inv),
        .i_inv_line(inv_line), .i_inv_addr(inv_addr), .o_rdata(rdata1), .o_rdav(rdav1));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < WAYS; w++)
            for (int i = 0; i < DEPTH; i++) m_vld[w][i] = 1'b0;
        p1 = '0;
        p2 = '0;
    endtask

    // Array-level effect of one clock edge; outputs always reflect the current array
    // state at the address sampled RD_LAT clken-edges ago.
    task automatic model_edge();
        if (clken) begin
            p2 = p1;
            p1 = raddr;
        end
        if (wen && clken) begin
            for (int w = 0; w < WAYS; w++) begin
                if (wway[w]) begin
                    for (int b = 0; b < BW; b++) begin
                        if (wben[b]) begin
                            m_data[w][waddr][8*b +: 8] = wdata[8*b +: 8];
                            m_known[w][waddr][b] = 1'b1;
                        end
                    end
                    m_vld[w][waddr] = 1'b1;
                end
            end
        end
        if (inv_line)
            for (int w = 0; w < WAYS; w++) m_vld[w][inv_addr] = 1'b0;
        if (inv)
            for (int w = 0; w < WAYS; w++)
                for (int i = 0; i < DEPTH; i++) m_vld[w][i] = 1'b0;
    endtask

    task automatic check_outs();
        logic [AW-1:0]    a;
        logic [WIDTH-1:0] mask, obs;
        logic             ov;
        for (int l = 1; l <= 2; l++) begin
            a = (l == 1) ? p1 : p2;
            for (int w = 0; w < WAYS; w++) begin
                ov  = (l == 1) ? rdav1[w] : rdav2[w];
                obs = (l == 1) ? rdata1[w*WIDTH +: WIDTH] : rdata2[w*WIDTH +: WIDTH];
                chk($sformatf("rdav_lat%0d_way%0d_idx%0d", l, w, a), 64'(ov), 64'(m_vld[w][a]));
                if (m_vld[w][a]) begin
                    mask = '0;
                    for (int b = 0; b < BW; b++)
                        if (m_known[w][a][b]) mask[8*b +: 8] = 8'hFF;
                    chk($sformatf("rdata_lat%0d_way%0d_idx%0d", l, w, a),
                        64'(obs & mask), 64'(m_data[w][a] & mask));
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outs();
    endtask

    task automatic idle();
        clken = 1'b1; wen = 1'b0; wway = '0; wben = '0; wdata = '0;
        inv = 1'b0; inv_line = 1'b0; inv_addr = '0;
    endtask

    task automatic wr(input int way, input logic [AW-1:0] a, input logic [WIDTH-1:0] d,
                      input logic [BW-1:0] be);
        wen = 1'b1; wway = '0; wway[way] = 1'b1; waddr = a; wdata = d; wben = be;
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        raddr = '0;
        waddr = '0;
        for (int w = 0; w < WAYS; w++)
            for (int i = 0; i < DEPTH; i++) begin
                m_known[w][i] = '0;
                m_data[w][i]  = '0;
            end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("reset_rdav_lat2", 64'(rdav2), 64'h0);
        chk("reset_rdav_lat1", 64'(rdav1), 64'h0);
        reset_n = 1'b1;

        // Read of a never-written index after reset.
        raddr = 5'd5; step();
        raddr = 5'd0; step();
        chk("read5_after_reset", 64'(rdav2), 64'h0);

        // Full write then read; async reset mid-read.
        wr(1, 5'd3, 32'hDEADBEEF, 4'hF); step();
        idle(); raddr = 5'd3; step();
        step();
        chk("read3_rdav", 64'(rdav2), 64'h2);
        chk("read3_data_way1", 64'(rdata2[WIDTH +: WIDTH]), 64'hDEADBEEF);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_rdav_lat2", 64'(rdav2), 64'h0);
        chk("async_reset_rdav_lat1", 64'(rdav1), 64'h0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;

        // Partial write forwarded into an in-flight read.
        wr(0, 5'd7, 32'hAABBCCDD, 4'hF); step();
        idle(); raddr = 5'd7; step();
        wr(0, 5'd7, 32'h11223344, 4'b0011); raddr = 5'd0; step();
        chk("fwd_partial_rdav_way0", 64'(rdav2[0]), 64'h1);
        chk("fwd_partial_data_way0", 64'(rdata2[0 +: WIDTH]), 64'hAABB3344);

        // Global invalidate coinciding with a write and an in-flight read.
        idle();
        for (int i = 0; i < 4; i++)
            for (int w = 0; w < WAYS; w++) begin
                wr(w, 5'(i), 32'h1000_0000 + 32'(i * 16 + w), 4'hF); step();
            end
        idle(); raddr = 5'd1; step();
        inv = 1'b1; wr(0, 5'd2, 32'h55555555, 4'hF); raddr = 5'd2; step();
        chk("inv_inflight_lat2", 64'(rdav2), 64'h0);
        chk("inv_inflight_lat1", 64'(rdav1), 64'h0);
        idle();
        for (int i = 0; i < 4; i++) begin
            raddr = 5'(i); step();
        end
        step();
        chk("inv_after_lat2", 64'(rdav2), 64'h0);

        // Line invalidate with reads of idx 1 and idx 2 in flight.
        for (int i = 1; i < 3; i++)
            for (int w = 0; w < WAYS; w++) begin
                wr(w, 5'(i), 32'h2000_0000 + 32'(i * 16 + w), 4'hF); step();
            end
        idle(); raddr = 5'd1; step();
        raddr = 5'd2; inv_line = 1'b1; inv_addr = 5'd1; step();
        chk("line_inv_idx1_lat2", 64'(rdav2), 64'h0);
        chk("line_inv_idx2_lat1", 64'(rdav1), 64'h3);
        idle(); raddr = 5'd0; step();
        chk("line_inv_idx2_lat2", 64'(rdav2), 64'h3);
        wr(0, 5'd1, 32'h31313131, 4'hF); step();
        wr(1, 5'd1, 32'h32323232, 4'hF); step();
        idle(); raddr = 5'd1; inv_line = 1'b1; inv_addr = 5'd1; step();
        chk("line_inv_idx1_lat1", 64'(rdav1), 64'h0);
        idle(); raddr = 5'd2; step();
        chk("line_inv_idx2_lat1b", 64'(rdav1), 64'h3);

        // Stall for 5 cycles with an ineffective write to the index being read.
        wr(0, 5'd4, 32'h12345678, 4'hF); step();
        idle(); raddr = 5'd4; step();
        step();
        wr(0, 5'd4, 32'hCAFEF00D, 4'hF); clken = 1'b0; raddr = 5'd9;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("stall_rdav_way0", 64'(rdav2[0]), 64'h1);
            chk("stall_data_way0", 64'(rdata2[0 +: WIDTH]), 64'h12345678);
        end
        idle(); raddr = 5'd4; step();
        step();
        step();
        chk("after_stall_data_way0", 64'(rdata2[0 +: WIDTH]), 64'h12345678);

        // Randomised traffic concentrated on a few indices to provoke collisions.
        for (int n = 0; n < 600; n++) begin
            clken    = ($urandom_range(0, 9) < 8);
            wen      = ($urandom_range(0, 9) < 5);
            wway     = ($urandom_range(0, 3) == 0) ? 2'b00 : (2'b01 << $urandom_range(0, 1));
            waddr    = 5'($urandom_range(0, 7));
            wdata    = $urandom;
            wben     = 4'($urandom_range(0, 15));
            raddr    = 5'($urandom_range(0, 7));
            inv      = ($urandom_range(0, 49) == 0);
            inv_line = ($urandom_range(0, 9) == 0);
            inv_addr = 5'($urandom_range(0, 7));
            step();
        end

        idle();
        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
